// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: PC generation, 1-cycle memory reads and a prefetch queue toward decode.
// Optional macro FETCH_BYPASS_EN presents a response arriving at an empty queue in the same cycle.
module fetch_queue_unit #(
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        INST_W   = 16,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              to_mem_req,
    output logic [ADDR_W-1:0] to_mem_addr,
    input  logic [INST_W-1:0] from_mem_data,
    input  logic              target_en,
    input  logic [ADDR_W-1:0] target,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] npc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [INST_W-1:0] mem_inst_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];

    logic              resp_live;
    logic              q_empty;
    logic              byp;
    logic              fire;
    logic              pop;
    logic              push;
    logic [INST_W-1:0] head_inst;
    logic [ADDR_W-1:0] head_pc;

    // Memory-facing and decode-facing outputs follow the same-cycle redirect and issue rule,
    // so they are decoded from state and inputs rather than registered.
    always_comb begin
        pc_d        = pc_q;
        inflight_d  = 1'b0;
        tag_d       = tag_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        to_mem_req  = 1'b0;
        to_mem_addr = '0;
        inst_valid  = 1'b0;
        inst        = '0;
        inst_pc     = '0;
        npc         = '0;

        resp_live = inflight_q && !target_en;
        q_empty   = (count_q == CNT_W'(0));
`ifdef FETCH_BYPASS_EN
        byp = q_empty && resp_live;
`else
        byp = 1'b0;
`endif
        head_inst = byp ? from_mem_data : mem_inst_q[rd_ptr_q];
        head_pc   = byp ? tag_q         : mem_pc_q[rd_ptr_q];

        inst_valid = !target_en && (!q_empty || byp);
        fire       = inst_valid && inst_ready;
        pop        = fire && !byp;
        push       = resp_live && !(fire && byp);

        if (inst_valid) begin
            inst    = head_inst;
            inst_pc = head_pc;
            npc     = head_pc + ADDR_W'(1);
        end

        // Slots are reserved at issue: queued entries plus the outstanding read never exceed DEPTH.
        to_mem_req = rst_n && (target_en ||
                     ((count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH)));
        if (to_mem_req) begin
            to_mem_addr = target_en ? target : pc_q;
            pc_d        = to_mem_addr + ADDR_W'(1);
            inflight_d  = 1'b1;
            tag_d       = to_mem_addr;
        end

        if (target_en) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; an entry is written at the tail together with the PC it was fetched from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else if (push) begin
            mem_inst_q[wr_ptr_q] <= from_mem_data;
            mem_pc_q[wr_ptr_q]   <= tag_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed vector table, wrap-around instance, and a
// queue-level reference model under random ready/redirect traffic with async reset.
module tb_fetch_queue_unit;

    localparam int unsigned AW    = 16;
    localparam int unsigned IW    = 16;
    localparam int unsigned DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req, valid, ready, ten;
    logic [AW-1:0] addr, tgt, ipc, npc;
    logic [IW-1:0] mdata, inst;
    logic          req2, valid2;
    logic [AW-1:0] addr2, ipc2, npc2;
    logic [IW-1:0] mdata2, inst2;

    int total = 0;
    int bad   = 0;

    fetch_queue_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .to_mem_req(req), .to_mem_addr(addr),
        .from_mem_data(mdata), .target_en(ten), .target(tgt),
        .inst_valid(valid), .inst_ready(ready), .inst(inst), .inst_pc(ipc), .npc(npc)
    );

    fetch_queue_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .to_mem_req(req2), .to_mem_addr(addr2),
        .from_mem_data(mdata2), .target_en(1'b0), .target(16'h0000),
        .inst_valid(valid2), .inst_ready(1'b1), .inst(inst2), .inst_pc(ipc2), .npc(npc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: 1-cycle latency, word at address a holds a+0x1000.
    always @(posedge clk) begin
        mdata  <= addr  + 16'h1000;
        mdata2 <= addr2 + 16'h1000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          rdy;
        logic          ten;
        logic [AW-1:0] tgt;
        logic          ereq;
        logic [AW-1:0] eaddr;
        logic          evalid;
        logic [AW-1:0] epc;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    task automatic setv(input int i, input logic r, input logic t, input logic [AW-1:0] g,
                        input logic eq, input logic [AW-1:0] ea, input logic ev,
                        input logic [AW-1:0] ep);
        vt[i] = '{r, t, g, eq, ea, ev, ep};
    endtask

    // Reference model state: captured PCs awaiting decode, the outstanding read, and next PC.
    logic [AW-1:0] mq [$];
    bit            infl_v;
    logic [AW-1:0] infl_pc;
    logic [AW-1:0] mpc;

    task automatic model_reset();
        mq.delete();
        infl_v  = 1'b0;
        infl_pc = '0;
        mpc     = 16'h0000;
    endtask

    // Called at posedge+1; drives inputs, checks at negedge, advances model, returns at next posedge+1.
    task automatic run_cycle(input bit r, input bit t, input logic [AW-1:0] g);
        bit            has_q, ev, eq, byp_take;
        logic [AW-1:0] ep, ea;
        ready = r; ten = t; tgt = g;
        @(negedge clk);
        has_q = (mq.size() > 0);
        ev    = !t && (has_q || (BYP && infl_v));
        ep    = has_q ? mq[0] : infl_pc;
        eq    = t || ((mq.size() + int'(infl_v)) < DEPTH);
        ea    = t ? g : mpc;
        chk("m_req", 32'(req), 32'(eq));
        if (eq) chk("m_addr", 32'(addr), 32'(ea));
        chk("m_valid", 32'(valid), 32'(ev));
        if (ev) begin
            chk("m_pc",   32'(ipc),  32'(ep));
            chk("m_inst", 32'(inst), 32'(16'(ep + 16'h1000)));
            chk("m_npc",  32'(npc),  32'(16'(ep + 16'h0001)));
        end
        if (t) begin
            mq.delete();
            infl_v  = 1'b1;
            infl_pc = g;
            mpc     = g + 16'h0001;
        end else begin
            byp_take = 1'b0;
            if (ev && r) begin
                if (has_q) void'(mq.pop_front());
                else       byp_take = 1'b1;
            end
            if (infl_v && !byp_take) mq.push_back(infl_pc);
            if (eq) begin
                infl_v  = 1'b1;
                infl_pc = mpc;
                mpc     = mpc + 16'h0001;
            end else begin
                infl_v = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] exp2;
        logic [AW-1:0] rt;
        bit            rr, rten;

        // Stall from reset, drain, redirect with 3 queued, back-to-back redirects.
        setv(0,  0, 0, 0,       1, 16'h0000, 0,   0);
        setv(1,  0, 0, 0,       1, 16'h0001, BYP, 16'h0000);
        setv(2,  0, 0, 0,       1, 16'h0002, 1,   16'h0000);
        setv(3,  0, 0, 0,       1, 16'h0003, 1,   16'h0000);
        for (int i = 4; i < 10; i++) setv(i, 0, 0, 0, 0, 0, 1, 16'h0000);
        setv(10, 1, 0, 0,       0, 16'h0000, 1,   16'h0000);
        setv(11, 1, 0, 0,       1, 16'h0004, 1,   16'h0001);
        setv(12, 1, 0, 0,       1, 16'h0005, 1,   16'h0002);
        setv(13, 1, 0, 0,       1, 16'h0006, 1,   16'h0003);
        setv(14, 1, 0, 0,       1, 16'h0007, 1,   16'h0004);
        setv(15, 0, 0, 0,       1, 16'h0008, 1,   16'h0005);
        setv(16, 0, 1, 16'h0040, 1, 16'h0040, 0,  0);
        setv(17, 1, 0, 0,       1, 16'h0041, BYP, 16'h0040);
        setv(18, 1, 0, 0,       1, 16'h0042, 1,   BYP ? 16'h0041 : 16'h0040);
        setv(19, 1, 1, 16'h0010, 1, 16'h0010, 0,  0);
        setv(20, 1, 1, 16'h0020, 1, 16'h0020, 0,  0);
        setv(21, 1, 0, 0,       1, 16'h0021, BYP, 16'h0020);
        setv(22, 1, 0, 0,       1, 16'h0022, 1,   BYP ? 16'h0021 : 16'h0020);
        setv(23, 1, 0, 0,       1, 16'h0023, 1,   BYP ? 16'h0022 : 16'h0021);

        rst_n = 1'b0; ready = 1'b0; ten = 1'b0; tgt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(req), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_inst", 32'(inst), 0);
        chk("rst_pc", 32'(ipc), 0);
        chk("rst_npc", 32'(npc), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        exp2 = 16'hFFFE;
        for (int i = 0; i < NV; i++) begin
            ready = vt[i].rdy; ten = vt[i].ten; tgt = vt[i].tgt;
            @(negedge clk);
            chk("t_req", 32'(req), 32'(vt[i].ereq));
            if (vt[i].ereq) chk("t_addr", 32'(addr), 32'(vt[i].eaddr));
            chk("t_valid", 32'(valid), 32'(vt[i].evalid));
            if (vt[i].evalid) begin
                chk("t_pc",   32'(ipc),  32'(vt[i].epc));
                chk("t_inst", 32'(inst), 32'(16'(vt[i].epc + 16'h1000)));
                chk("t_npc",  32'(npc),  32'(16'(vt[i].epc + 16'h0001)));
            end
            // Wrap-around instance: free-running from 0xFFFE.
            if (i < 3) begin
                chk("w_req",  32'(req2),  1);
                chk("w_addr", 32'(addr2), 32'(16'(16'hFFFE + 16'(i))));
            end
            if (i == 3) chk("w_valid", 32'(valid2), 1);
            if (valid2) begin
                chk("w_pc",  32'(ipc2), 32'(exp2));
                chk("w_npc", 32'(npc2), 32'(16'(exp2 + 16'h0001)));
                exp2 = exp2 + 16'h0001;
            end
            @(posedge clk);
            #1;
        end

        // Fresh reset, then random traffic against the queue-level model.
        rst_n = 1'b0; ready = 1'b0; ten = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            rr   = ((c % 200) < 12) ? 1'b0 : ($urandom_range(0, 2) != 0);
            rten = ($urandom_range(0, 19) == 0);
            rt   = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            run_cycle(rr, rten, rt);
        end

        // Fill the queue with a read outstanding, then assert reset mid-cycle.
        for (int c = 0; c < 3; c++) run_cycle(1'b0, 1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(req), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_addr", 32'(addr), 0);
        chk("arst_inst", 32'(inst), 0);
        chk("arst_pc", 32'(ipc), 0);
        chk("arst_npc", 32'(npc), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) run_cycle(($urandom_range(0, 3) != 0), 1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
